frame_buffer_sequencer: RTL
===========================

Name: frame_buffer_sequencer

Overview:
- Parametrised N-buffer frame sequencer for the VGA pipeline. Generalises the fixed two-buffer toggle to NUM_BUFS buffers (double or triple buffering).
- Tracks three things: which buffer the display scans out, which buffer the renderer draws into, and how many finished frames are queued.
- Advances the display buffer only at the end of the visible raster, and only when a completed frame is queued. Otherwise it repeats the current frame and counts a dropped frame.
- Sits between the VGA timing counters and the renderer/memory address mux.

Parameters:
- NUM_BUFS, 2, number of frame buffers (2..4).
- BUF_W, 2, width of buffer index and queue count; 2^BUF_W >= NUM_BUFS.
- H_LAST, 639, hcount value of the last visible pixel.
- V_LAST, 479, vcount value of the last visible line.
- CNT_W, 8, width of the frame and drop counters.

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- rst_n  input  1  synchronous, active-low reset.
- hcount  input  11  horizontal pixel counter from VGA timing.
- vcount  input  11  vertical line counter from VGA timing.
- draw_done  input  1  one-cycle pulse: renderer finished draw_buf.
- disp_buf  output  BUF_W  index of the buffer being scanned out.
- draw_buf  output  BUF_W  index of the buffer the renderer owns.
- draw_ready  output  1  renderer may draw into draw_buf.
- swap_pulse  output  1  one-cycle pulse: disp_buf just advanced.
- frame_count  output  CNT_W  frame-end events since reset; wraps.
- drop_count  output  CNT_W  frame ends with no queued frame; saturates.
- overflow  output  1  sticky: draw_done received while draw_ready=0.

Behaviour:
- Synchronous active-low reset; all outputs registered. Values on the cycle after rst_n sampled low:
  - disp_buf=0, draw_buf=1, queue count q=0, draw_ready=1
  - swap_pulse=0, frame_count=0, drop_count=0, overflow=0
  - fe_prev=1, so there is no spurious event if the raster sits at H_LAST/V_LAST when reset releases.
- Frame-end detection:
  - fe_raw = (hcount==H_LAST && vcount==V_LAST).
  - fe_prev <= fe_raw every cycle.
  - Event fe = fe_raw & ~fe_prev: exactly one event per frame, however many clocks per pixel.
- Queue:
  - q counts completed, not-yet-displayed buffers; range 0..NUM_BUFS-1.
  - draw_buf = (disp_buf + 1 + q) mod NUM_BUFS.
  - draw_ready = (q < NUM_BUFS-1).
  - All modular increments wrap: idx==NUM_BUFS-1 goes to 0.
- draw_done accepted (acc) only when draw_ready=1 in that cycle: q increments.
- draw_done with draw_ready=0: ignored (q unchanged) and overflow <= 1. Only reset clears overflow.
- On fe:
  - frame_count increments.
  - If q>0 in that cycle: disp_buf <= disp_buf+1 mod NUM_BUFS, q decrements, swap_pulse=1 in the next cycle.
  - If q==0: disp_buf holds, drop_count increments, saturating at all-ones.
- Simultaneous fe and acc:
  - Swap decision uses q before the update.
  - Net q is unchanged if a swap occurs; q=1 if q was 0 (no swap, drop counted).
  - The newly finished buffer is not shown until the next fe.
- Simultaneous fe and draw_done with draw_ready=0: the swap proceeds, draw_done is ignored, and overflow is set.
- Latency:
  - disp_buf, draw_buf, draw_ready, q and swap_pulse update at the clock edge ending the fe/acc cycle, so they are visible 1 cycle later.
  - swap_pulse is high for exactly 1 cycle.
- Reset mid-frame or mid-draw: everything returns to reset values. The renderer must treat draw_ready=1, draw_buf=1 as a fresh start.
- NUM_BUFS=2 reproduces double buffering, with swaps gated by draw completion. NUM_BUFS=3 lets the renderer start a new frame while one completed frame waits for frame end.

Test Plan:
- Reset, NUM_BUFS=2, raster running, no draw_done over 3 frames -> disp_buf=0, draw_buf=1, swap_pulse never asserted, frame_count=3, drop_count=3.
- NUM_BUFS=2: draw_done mid-frame, then frame end -> draw_ready=0 until fe; 1 cycle after fe: disp_buf=1, draw_buf=0, swap_pulse=1 for one cycle, draw_ready=1.
- NUM_BUFS=3: two draw_done pulses before fe -> q=2, draw_buf=0, draw_ready=0; third draw_done sets overflow=1; after fe: disp_buf=1, q=1, draw_buf=0, draw_ready=1.
- draw_done in the same cycle as fe with q=0 -> no swap, drop_count+1, q=1; next fe swaps to disp_buf=1.
- hcount/vcount held at 639/479 for 4 clocks (pixel clock divider) -> exactly one fe: frame_count+1, one swap_pulse. Reset asserted with rst_n=0 while q=2 -> all outputs at reset values next cycle.
- CNT_W=2, 5 frames without draw_done -> drop_count saturates at 3; frame_count wraps to 1.

Source files
------------

// File: rtl/frame_buffer_sequencer_if.sv
// Raster, renderer handshake and status bundle between the VGA pipeline and
// the frame buffer sequencer.
interface frame_buffer_sequencer_if #(
    parameter int BUF_W = 2,
    parameter int CNT_W = 8
);
    logic [10:0]      hcount;
    logic [10:0]      vcount;
    logic             draw_done;
    logic [BUF_W-1:0] disp_buf;
    logic [BUF_W-1:0] draw_buf;
    logic             draw_ready;
    logic             swap_pulse;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;

    modport slave (
        input  hcount, vcount, draw_done,
        output disp_buf, draw_buf, draw_ready, swap_pulse,
        output frame_count, drop_count, overflow
    );

    modport master (
        output hcount, vcount, draw_done,
        input  disp_buf, draw_buf, draw_ready, swap_pulse,
        input  frame_count, drop_count, overflow
    );
endinterface

// File: rtl/frame_buffer_sequencer.sv
// N-buffer frame sequencer: tracks display/draw buffers and the completed-frame
// queue, advancing the display buffer only at the end of the visible raster.
module frame_buffer_sequencer #(
    parameter int NUM_BUFS = 2,
    parameter int BUF_W    = 2,
    parameter int H_LAST   = 639,
    parameter int V_LAST   = 479,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    frame_buffer_sequencer_if.slave bus
);

    logic [BUF_W-1:0] disp_buf_q, disp_buf_d;
    logic [BUF_W-1:0] draw_buf_q, draw_buf_d;
    logic [BUF_W-1:0] q_q, q_d;
    logic             draw_ready_q, draw_ready_d;
    logic             swap_pulse_q, swap_pulse_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;
    logic             fe_prev_q, fe_prev_d;

    logic fe_raw, fe, acc, swap;

    // Sum is at most 2*NUM_BUFS-1, so a single conditional subtract is a full mod.
    function automatic logic [BUF_W-1:0] wrap_idx(input logic [BUF_W:0] s);
        if (s >= (BUF_W+1)'(NUM_BUFS))
            return BUF_W'(s - (BUF_W+1)'(NUM_BUFS));
        else
            return s[BUF_W-1:0];
    endfunction

    always_comb begin
        fe_raw = (bus.hcount == 11'(H_LAST)) && (bus.vcount == 11'(V_LAST));
        fe     = fe_raw & ~fe_prev_q;
        acc    = bus.draw_done & draw_ready_q;
        swap   = fe && (q_q != '0);

        fe_prev_d     = fe_raw;
        swap_pulse_d  = swap;
        overflow_d    = overflow_q | (bus.draw_done & ~draw_ready_q);
        disp_buf_d    = disp_buf_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;

        // Swap decision uses the queue depth before this cycle's accept.
        q_d = q_q + BUF_W'(acc) - BUF_W'(swap);

        if (fe) begin
            frame_count_d = frame_count_q + 1'b1;
            if (swap)
                disp_buf_d = wrap_idx({1'b0, disp_buf_q} + (BUF_W+1)'(1));
            else if (drop_count_q != {CNT_W{1'b1}})
                drop_count_d = drop_count_q + 1'b1;
        end

        draw_buf_d   = wrap_idx({1'b0, disp_buf_d} + {1'b0, q_d} + (BUF_W+1)'(1));
        draw_ready_d = (q_d < BUF_W'(NUM_BUFS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_buf_q    <= '0;
            draw_buf_q    <= BUF_W'(1);
            q_q           <= '0;
            draw_ready_q  <= 1'b1;
            swap_pulse_q  <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            fe_prev_q     <= 1'b1;
        end else begin
            disp_buf_q    <= disp_buf_d;
            draw_buf_q    <= draw_buf_d;
            q_q           <= q_d;
            draw_ready_q  <= draw_ready_d;
            swap_pulse_q  <= swap_pulse_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            fe_prev_q     <= fe_prev_d;
        end
    end

    assign bus.disp_buf    = disp_buf_q;
    assign bus.draw_buf    = draw_buf_q;
    assign bus.draw_ready  = draw_ready_q;
    assign bus.swap_pulse  = swap_pulse_q;
    assign bus.frame_count = frame_count_q;
    assign bus.drop_count  = drop_count_q;
    assign bus.overflow    = overflow_q;

endmodule
